sdram_stream_writer: RTL and testbench
======================================

Name: sdram_stream_writer

Overview:
Parametrised successor to the single-purpose SDRAM test writer. It captures words from a slow, level-signalled source (SD card FAT32 reader or fake reader) into a small FIFO, then drains them into the SDRAM controller's Avalon-style write port, honouring wait-request. It adds a configurable base address, data and address widths, FIFO buffering, overflow detection and abort. It sits between the SD reader and the SDRAM controller in the frame-load path.

Parameters:
DATA_W, 16, width of the data word
ADDR_W, 25, width of the SDRAM word address
FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2
FIFO_AW, 3, log2(FIFO_DEPTH)

Ports:
iCLK  in  1  system clock; single clock domain
iRST  in  1  asynchronous, active-high reset
iTRIGGER  in  1  level; rising starts a transfer, falling ends or aborts it
iBASE_ADDR  in  ADDR_W  first write address; sampled on the start cycle
iSRC_DATA  in  DATA_W  source data; valid while iSRC_READY is high
iSRC_READY  in  1  source level ready; each rising edge carries one word
iSRC_LAST  in  1  qualifies the word as final; sampled with iSRC_DATA
iWAIT_REQUEST  in  1  SDRAM controller stall
oWR_EN  out  1  write request
oWR_DATA  out  DATA_W  write data
oWR_ADDR  out  ADDR_W  write address
oDONE  out  1  high in IDLE and DONE_WAIT
oOVERFLOW  out  1  sticky; a source word was dropped
oABORTED  out  1  sticky; trigger fell before the last word was written

Behaviour:
- Reset values: state IDLE, oWR_EN=0, oWR_DATA=0, oWR_ADDR=0, oDONE=1, oOVERFLOW=0, oABORTED=0, FIFO empty, edge register 0.
- States: IDLE, RUN, DONE_WAIT.
- IDLE: when iTRIGGER=1, go to RUN. On that cycle: address counter <= iBASE_ADDR, FIFO flushed, oOVERFLOW and oABORTED cleared, edge register <= iSRC_READY. No pushes occur in IDLE.
- Capture (RUN only): edge register holds the previous iSRC_READY. When iSRC_READY=1 and the previous value was 0, push {iSRC_LAST, iSRC_DATA} at that clock edge. Exactly one push per rising edge, whatever the level duration.
- Latency: a rising edge visible in cycle t gives oWR_EN=1 in cycle t+1 if the FIFO was empty.
- Drain (RUN): oWR_EN = FIFO not empty. oWR_DATA = head data; oWR_ADDR = address counter.
  - Pop when oWR_EN=1 and iWAIT_REQUEST=0; the address counter increments by 1 and wraps modulo 2^ADDR_W.
  - While iWAIT_REQUEST=1, oWR_EN, oWR_DATA and oWR_ADDR are held stable.
- Last word: a pop whose entry has the last flag set moves RUN to DONE_WAIT. Entries behind it are discarded and later edges are ignored.
- Full FIFO: a push with the FIFO full and no pop in the same cycle is dropped and sets oOVERFLOW. A push and a pop in the same cycle while full are both accepted. A push and a pop in the same cycle while empty are not possible, because no head exists.
- Abort: iTRIGGER=0 in RUN moves to IDLE next cycle, sets oABORTED, flushes the FIFO and forces oWR_EN=0. This takes priority over a pending pop; the handshake may be cut mid-stall.
- DONE_WAIT: oWR_EN=0; return to IDLE when iTRIGGER=0.
- Outputs oWR_EN, oWR_DATA and oWR_ADDR are combinational from FIFO head and registers; there is no combinational path from iSRC_*.
- Reset mid-operation returns every output immediately to its reset value.

Optional Feature:
Macro SDRAM_STREAM_WRITER_STATS_EN.
- Defined: adds output oWORD_COUNT [ADDR_W] (writes accepted since start; cleared on start; saturates at all-ones) and oSTALL_COUNT [16] (cycles with oWR_EN=1 and iWAIT_REQUEST=1; cleared on start; saturates at 16'hFFFF).
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package sdram_writer_pkg: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE_WAIT=2'd2) and default widths DATA_W=16, ADDR_W=25.
- One sub-module, sdram_writer_fifo: synchronous FIFO, width DATA_W+1, depth FIFO_DEPTH, with push, pop, flush, full, empty and head ports. The parent holds the capture logic, FSM and address counter.

Test Plan:
- Base=25'h0000100; 4 source pulses 16'hA001..A004, last on the 4th; iWAIT_REQUEST=0 -> writes at 0x100..0x103 with matching data, then DONE_WAIT, oDONE=1, oOVERFLOW=0.
- Same stimulus with iWAIT_REQUEST high for 5 cycles on the 2nd write -> oWR_EN, addr 0x101 and data A002 held stable for 6 cycles, no duplicate or missing writes.
- Base=25'h1FFFFFE; 4 words -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
- iWAIT_REQUEST stuck high while 10 rising edges arrive, FIFO_DEPTH=8 -> exactly 8 words written once released, oOVERFLOW=1.
- Trigger dropped after 2 of 6 words -> IDLE next cycle, oABORTED=1, oWR_EN=0; a new trigger clears oABORTED and restarts at the new base.
- iSRC_READY held high for 12 cycles per word (fake reader pacing, 64 words) -> exactly 64 writes, one per rising edge.

Source files
------------

// File: rtl/sdram_writer_pkg.sv
// sdram_writer_pkg: shared state encoding and default widths for the SDRAM stream writer.
package sdram_writer_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE_WAIT = 2'd2} state_t;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 25;
endpackage

// File: rtl/sdram_writer_fifo.sv
// sdram_writer_fifo: synchronous FIFO with flush; flush wins over a same-cycle push or pop.
module sdram_writer_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 8,
   parameter int AW    = 3
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign head    = mem[rp_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   always_comb begin
      wp_d  = flush ? '0 : wp_q + AW'(do_push);
      rp_d  = flush ? '0 : rp_q + AW'(do_pop);
      cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wp_q] <= din;
   end
endmodule

// File: rtl/sdram_stream_writer.sv
// sdram_stream_writer: captures level-signalled source words into a FIFO and drains them to an SDRAM write port.
// Optional SDRAM_STREAM_WRITER_STATS_EN adds accepted-word and stall-cycle counters.
module sdram_stream_writer
   import sdram_writer_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3
)(
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iTRIGGER,
   input  logic [ADDR_W-1:0] iBASE_ADDR,
   input  logic [DATA_W-1:0] iSRC_DATA,
   input  logic              iSRC_READY,
   input  logic              iSRC_LAST,
   input  logic              iWAIT_REQUEST,
   output logic              oWR_EN,
   output logic [DATA_W-1:0] oWR_DATA,
   output logic [ADDR_W-1:0] oWR_ADDR,
   output logic              oDONE,
   output logic              oOVERFLOW,
   output logic              oABORTED
`ifdef SDRAM_STREAM_WRITER_STATS_EN
   ,output logic [ADDR_W-1:0] oWORD_COUNT,
   output logic [15:0]       oSTALL_COUNT
`endif
);
   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic edge_q, edge_d, ovf_q, ovf_d, abt_q, abt_d;
   logic start, abort, push, pop, last_pop, flush, full, empty;
   logic [DATA_W:0] head;
   sdram_writer_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
      .clk(iCLK), .rst(iRST), .push(push), .pop(pop), .flush(flush),
      .din({iSRC_LAST, iSRC_DATA}), .full(full), .empty(empty), .head(head)
   );
   assign start     = state_q == ST_IDLE && iTRIGGER;
   assign abort     = state_q == ST_RUN && !iTRIGGER;
   assign push      = state_q == ST_RUN && iSRC_READY && !edge_q;
   assign oWR_EN    = state_q == ST_RUN && !empty;
   // abort beats a pending pop, so a write cut mid-handshake is never counted as accepted
   assign pop       = oWR_EN && !iWAIT_REQUEST && iTRIGGER;
   assign last_pop  = pop && head[DATA_W];
   assign flush     = start || abort || last_pop;
   assign oWR_DATA  = oWR_EN ? head[DATA_W-1:0] : '0;
   assign oWR_ADDR  = addr_q;
   assign oDONE     = state_q != ST_RUN;
   assign oOVERFLOW = ovf_q;
   assign oABORTED  = abt_q;
   always_comb begin
      state_d = start ? ST_RUN :
                abort ? ST_IDLE :
                last_pop ? ST_DONE_WAIT :
                (state_q == ST_DONE_WAIT && !iTRIGGER) ? ST_IDLE : state_q;
      addr_d  = start ? iBASE_ADDR : pop ? addr_q + ADDR_W'(1) : addr_q;
      edge_d  = iSRC_READY;
      ovf_d   = start ? 1'b0 : ovf_q || (push && full && !pop);
      abt_d   = start ? 1'b0 : abt_q || abort;
   end
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         edge_q  <= 1'b0;
         ovf_q   <= 1'b0;
         abt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         edge_q  <= edge_d;
         ovf_q   <= ovf_d;
         abt_q   <= abt_d;
      end
   end
`ifdef SDRAM_STREAM_WRITER_STATS_EN
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic [15:0] scnt_q, scnt_d;
   always_comb begin
      wcnt_d = start ? '0 : (pop && !(&wcnt_q)) ? wcnt_q + ADDR_W'(1) : wcnt_q;
      scnt_d = start ? '0 : (oWR_EN && iWAIT_REQUEST && !(&scnt_q)) ? scnt_q + 16'd1 : scnt_q;
   end
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         wcnt_q <= '0;
         scnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         scnt_q <= scnt_d;
      end
   end
   assign oWORD_COUNT  = wcnt_q;
   assign oSTALL_COUNT = scnt_q;
`endif
endmodule

// File: tb/tb_sdram_stream_writer.sv
// tb_sdram_stream_writer: scoreboard bench; stimulus queues expected (addr,data) writes, a monitor pops and compares.
module tb_sdram_stream_writer;
   localparam int DW = 16;
   localparam int AW = 25;
   logic clk = 1'b0;
   logic rst, trig, srdy, slast;
   logic wreq = 1'b0;
   logic [AW-1:0] base;
   logic [DW-1:0] sdata;
   logic wr_en, done, ovf, abt;
   logic [DW-1:0] wdata;
   logic [AW-1:0] waddr;
`ifdef SDRAM_STREAM_WRITER_STATS_EN
   logic [AW-1:0] wcnt;
   logic [15:0] scnt;
`endif
   int checks = 0, failures = 0;
   int wmode = 0, acc = 0, nst = 0, held = 0, a101 = 0;
   logic [AW+DW-1:0] q [$];
   logic pstall = 1'b0;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pdata;

   always #5 clk = ~clk;

   sdram_stream_writer dut (
      .iCLK(clk), .iRST(rst), .iTRIGGER(trig), .iBASE_ADDR(base),
      .iSRC_DATA(sdata), .iSRC_READY(srdy), .iSRC_LAST(slast), .iWAIT_REQUEST(wreq),
      .oWR_EN(wr_en), .oWR_DATA(wdata), .oWR_ADDR(waddr), .oDONE(done),
      .oOVERFLOW(ovf), .oABORTED(abt)
`ifdef SDRAM_STREAM_WRITER_STATS_EN
      , .oWORD_COUNT(wcnt), .oSTALL_COUNT(scnt)
`endif
   );

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask

   // wait-request patterns: 0 never, 1 random, 2 stuck high, 3 five-cycle stall on the second write
   always @(posedge clk) begin
      #1;
      if (wmode == 1) wreq = ($urandom_range(0, 3) == 0);
      else if (wmode == 2) wreq = 1'b1;
      else if (wmode == 3) begin
         wreq = wr_en && acc == 1 && held < 5;
         if (wreq) held++;
      end else wreq = 1'b0;
   end

   always @(negedge clk) begin
      if (rst) pstall = 1'b0;
      else begin
         if (pstall) begin
            chk("hold_wr_en", wr_en, 1);
            chk("hold_addr", waddr, paddr);
            chk("hold_data", wdata, pdata);
         end
         if (wmode == 3 && wr_en && waddr == 25'h101) a101++;
         if (wr_en && wreq) nst++;
         if (wr_en && !wreq && trig) begin
            acc++;
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write actual=%0h:%0h required=none", waddr, wdata);
            end else begin
               logic [AW+DW-1:0] e;
               e = q.pop_front();
               checks--;
               chk("write_addr", waddr, e[AW+DW-1:DW]);
               chk("write_data", wdata, e[DW-1:0]);
            end
         end
         pstall = wr_en && wreq && trig;
         paddr = waddr;
         pdata = wdata;
      end
   end

   task automatic start(input logic [AW-1:0] b);
      acc = 0; nst = 0; held = 0; a101 = 0;
      base = b; trig = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic pulse(input logic [DW-1:0] d, input logic l, input int hi, input int lo,
                        input bit ex, input logic [AW-1:0] a);
      if (ex) q.push_back({a, d});
      sdata = d; slast = l; srdy = 1'b1;
      repeat (hi) @(posedge clk);
      #1 srdy = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
   endtask

   task automatic end_xfer(input logic ovf_exp);
      for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
      chk("done", done, 1);
      chk("overflow", ovf, ovf_exp);
      chk("aborted", abt, 0);
      chk("queue_drained", q.size(), 0);
`ifdef SDRAM_STREAM_WRITER_STATS_EN
      chk("word_count", wcnt, acc);
      chk("stall_count", scnt, nst);
`endif
      @(posedge clk); #1 trig = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] b;
      rst = 1'b1; trig = 1'b0; srdy = 1'b0; slast = 1'b0; sdata = '0; base = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wr_en", wr_en, 0);
      chk("reset_data", wdata, 0);
      chk("reset_addr", waddr, 0);
      chk("reset_done", done, 1);
      chk("reset_overflow", ovf, 0);
      chk("reset_aborted", abt, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // basic four-word burst with latency check on the first word
      wmode = 0;
      start(25'h100);
      chk("running_done_low", done, 0);
      q.push_back({25'h100, 16'hA001});
      sdata = 16'hA001; slast = 1'b0; srdy = 1'b1;
      @(negedge clk); chk("latency_cycle_t", wr_en, 0);
      @(negedge clk); chk("latency_cycle_t1", wr_en, 1);
      @(posedge clk); #1 srdy = 1'b0;
      @(posedge clk); #1;
      for (int i = 1; i < 4; i++) pulse(16'(32'hA001 + i), i == 3, 2, 2, 1, 25'(32'h100 + i));
      end_xfer(0);

      // five-cycle stall on the second write
      wmode = 3;
      start(25'h100);
      for (int i = 0; i < 4; i++) pulse(16'(32'hA001 + i), i == 3, 2, 3, 1, 25'(32'h100 + i));
      end_xfer(0);
      chk("stall_cycles_at_0x101", a101, 6);

      // address wrap with random stalls
      wmode = 1;
      start(25'h1FFFFFE);
      for (int i = 0; i < 4; i++) pulse(16'($urandom), i == 3, 1, 2, 1, 25'h1FFFFFE + 25'(i));
      end_xfer(0);

      // overflow: ten edges into an eight-entry FIFO while stalled
      wmode = 2;
      b = 25'($urandom);
      start(b);
      for (int i = 0; i < 10; i++) pulse(16'($urandom), i == 7, 1, 1, i < 8, b + 25'(i));
      chk("overflow_while_stalled", ovf, 1);
      chk("wr_en_while_full", wr_en, 1);
      wmode = 0;
      end_xfer(1);

      // abort with buffered words, then restart at a new base
      wmode = 2;
      start(25'($urandom));
      for (int i = 0; i < 2; i++) pulse(16'($urandom), 1'b0, 1, 2, 0, '0);
      chk("pending_before_abort", wr_en, 1);
      trig = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("abort_done", done, 1);
      chk("abort_flag", abt, 1);
      chk("abort_wr_en", wr_en, 0);
      wmode = 0;
      @(posedge clk); #1;
      b = 25'($urandom);
      start(b);
      chk("restart_clears_abort", abt, 0);
      chk("restart_addr", waddr, b);
      chk("restart_wr_en_flushed", wr_en, 0);
      for (int i = 0; i < 3; i++) pulse(16'($urandom), i == 2, 2, 2, 1, b + 25'(i));
      end_xfer(0);

      // fake-reader pacing: long ready levels, one write per rising edge
      wmode = 1;
      b = 25'($urandom);
      start(b);
      for (int i = 0; i < 64; i++)
         pulse(16'($urandom), i == 63, 12, $urandom_range(1, 4), 1, b + 25'(i));
      end_xfer(0);
      chk("paced_write_count", acc, 64);

      // asynchronous reset mid-transfer
      wmode = 2;
      start(25'h0ABCDE);
      for (int i = 0; i < 2; i++) pulse(16'($urandom), 1'b0, 1, 1, 0, '0);
      rst = 1'b1; trig = 1'b0;
      #1;
      chk("midreset_wr_en", wr_en, 0);
      chk("midreset_addr", waddr, 0);
      chk("midreset_data", wdata, 0);
      chk("midreset_done", done, 1);
      q.delete();
      wmode = 0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_reset_wr_en", wr_en, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
